// File: rtl/des_pkg.sv
// DES key-schedule constants, permutation tables and C/D rotate helpers.
// Pure combinational functions with no latency of their own and no flow control.
package des_pkg;

  localparam int KEY_W = 64;
  localparam int CD_W  = 28;
  localparam int SK_W  = 48;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Entries are 1-based DES bit numbers; DES bit 1 is the MSB of the source vector.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [2*CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [2*CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < 2*CD_W; i++) begin
      r[6'(2*CD_W-1 - i)] = k[6'(KEY_W - PC1_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic [SK_W-1:0] pc2(input logic [2*CD_W-1:0] cd);
    logic [SK_W-1:0] r;
    r = '0;
    for (int i = 0; i < SK_W; i++) begin
      r[6'(SK_W-1 - i)] = cd[6'(2*CD_W - PC2_TAB[i])];
    end
    return r;
  endfunction

  // Only shift amounts 1 and 2 occur in the schedule; anything other than 2 rotates by 1.
  function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
  endfunction

  function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
  endfunction

endpackage

// File: rtl/des_key_sched_seq_if.sv
// Key-in / subkey-out handshake bundle; master is the key source and subkey consumer.
// Both directions use valid/ready, and the slave side stalls on ready low.
interface des_key_sched_seq_if;
  import des_pkg::*;

  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key;
  logic             mode;
  logic             sk_valid;
  logic             sk_ready;
  logic [SK_W-1:0]  sk;
  logic [3:0]       sk_round;
  logic             sk_last;

  modport master (
    output key_valid, key, mode, sk_ready,
    input  key_ready, sk_valid, sk, sk_round, sk_last
  );

  modport slave (
    input  key_valid, key, mode, sk_ready,
    output key_ready, sk_valid, sk, sk_round, sk_last
  );

endinterface

// File: rtl/des_pc2.sv
// DES PC-2 permutation, 56-bit C||D to 48-bit subkey, purely combinational.
// Zero latency with no flow control of its own.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0] i_cd,
  output logic [SK_W-1:0]   o_sk
);

  assign o_sk = pc2(i_cd);

endmodule

// File: rtl/des_key_sched_seq.sv
// Sequential DES subkey streamer: K1..K16 (encrypt) or K16..K1 (decrypt) by rotating C/D in place.
// The first subkey appears 1 cycle after key accept; it holds all outputs while sk_ready is low.
module des_key_sched_seq
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  des_key_sched_seq_if.slave io_bus
);

  state_t            r_state;
  logic              r_mode;
  logic [CD_W-1:0]   r_c;
  logic [CD_W-1:0]   r_d;
  logic [3:0]        r_round;
  logic              r_key_ready;
  logic              r_sk_valid;
  logic              r_sk_last;

  logic [2*CD_W-1:0] w_cd0;
  logic [CD_W-1:0]   w_c0;
  logic [CD_W-1:0]   w_d0;
  logic [3:0]        w_round_nxt;
  logic              w_is_last;
  logic              w_last_nxt;
  logic [SK_W-1:0]   w_sk;

  assign w_cd0       = pc1(io_bus.key);
  assign w_c0        = w_cd0[2*CD_W-1:CD_W];
  assign w_d0        = w_cd0[CD_W-1:0];
  assign w_is_last   = r_mode ? (r_round == 4'd0) : (r_round == 4'd15);
  assign w_round_nxt = r_mode ? (r_round - 4'd1) : (r_round + 4'd1);
  assign w_last_nxt  = r_mode ? (w_round_nxt == 4'd0) : (w_round_nxt == 4'd15);

  des_pc2 u_pc2 (
    .i_cd ({r_c, r_d}),
    .o_sk (w_sk)
  );

  assign io_bus.key_ready = r_key_ready;
  assign io_bus.sk_valid  = r_sk_valid;
  assign io_bus.sk        = w_sk;
  assign io_bus.sk_round  = r_round;
  assign io_bus.sk_last   = r_sk_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= 1'b0;
      r_c         <= '0;
      r_d         <= '0;
      r_round     <= 4'd0;
      r_key_ready <= 1'b1;
      r_sk_valid  <= 1'b0;
      r_sk_last   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.key_valid) begin
            r_state     <= ST_RUN;
            r_mode      <= io_bus.mode;
            r_key_ready <= 1'b0;
            r_sk_valid  <= 1'b1;
            r_sk_last   <= 1'b0;
            // Total rotation over 16 rounds is 28, so C16/D16 equal C0/D0.
            if (io_bus.mode) begin
              r_c     <= w_c0;
              r_d     <= w_d0;
              r_round <= 4'd15;
            end else begin
              r_c     <= rotl28(w_c0, 2'd1);
              r_d     <= rotl28(w_d0, 2'd1);
              r_round <= 4'd0;
            end
          end
        end
        ST_RUN: begin
          if (io_bus.sk_ready) begin
            if (w_is_last) begin
              r_state     <= ST_IDLE;
              r_key_ready <= 1'b1;
              r_sk_valid  <= 1'b0;
              r_sk_last   <= 1'b0;
            end else begin
              r_round   <= w_round_nxt;
              r_sk_last <= w_last_nxt;
              if (r_mode) begin
                r_c <= rotr28(r_c, SHIFT[r_round]);
                r_d <= rotr28(r_d, SHIFT[r_round]);
              end else begin
                r_c <= rotl28(r_c, SHIFT[w_round_nxt]);
                r_d <= rotl28(r_d, SHIFT[w_round_nxt]);
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
